// File: rtl/sbox_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sbox_share_ctrl
// Brief   : Time-shares a bank of LANES S-boxes between the round datapath
//           (16-byte SubBytes) and the key schedule (4-byte SubWord).
// Revision: 1.0 - initial release
// ============================================================================
module sbox_share_ctrl #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dp_req_valid,
    output logic               dp_req_ready,
    input  logic [127:0]       dp_req_data,
    output logic               dp_rsp_valid,
    input  logic               dp_rsp_ready,
    output logic [127:0]       dp_rsp_data,
    input  logic               ks_req_valid,
    output logic               ks_req_ready,
    input  logic [31:0]        ks_req_data,
    output logic               ks_rsp_valid,
    input  logic               ks_rsp_ready,
    output logic [31:0]        ks_rsp_data,
    output logic [8*LANES-1:0] sb_in,
    input  logic [8*LANES-1:0] sb_out,
    output logic               busy
);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
        end
    endgenerate

    localparam int         C_SHIFT   = (LANES == 4) ? 2 : ((LANES == 2) ? 1 : 0);
    localparam logic [3:0] c_dp_last = 4'(16 / LANES - 1);
    localparam logic [3:0] c_ks_last = 4'(4 / LANES - 1);

    localparam logic [2:0] c_idle   = 3'd0;
    localparam logic [2:0] c_dp_run = 3'd1;
    localparam logic [2:0] c_dp_rsp = 3'd2;
    localparam logic [2:0] c_ks_run = 3'd3;
    localparam logic [2:0] c_ks_rsp = 3'd4;

    logic [2:0]   r_state;
    logic         r_last_ks;
    logic [3:0]   r_beat;
    logic [127:0] r_src;
    logic [127:0] r_res;

    logic         w_idle;
    logic         w_run;
    logic         w_last;
    logic [6:0]   w_shamt;
    logic [127:0] w_src_sh;
    logic [127:0] w_lane_res;

    assign w_idle = (r_state == c_idle);
    assign w_run  = (r_state == c_dp_run) || (r_state == c_ks_run);

    // Bit offset of the first byte handled by the current beat.
    assign w_shamt    = {4'(r_beat << C_SHIFT), 3'b000};
    assign w_src_sh   = r_src >> w_shamt;
    assign w_lane_res = {{(128 - 8 * LANES){1'b0}}, sb_out} << w_shamt;
    assign w_last     = (r_beat == ((r_state == c_dp_run) ? c_dp_last : c_ks_last));

    assign sb_in = w_run ? w_src_sh[8*LANES-1:0] : '0;
    assign busy  = !w_idle;

    assign dp_req_ready = w_idle && dp_req_valid && (!ks_req_valid || r_last_ks);
    assign ks_req_ready = w_idle && ks_req_valid && (!dp_req_valid || !r_last_ks);

    assign dp_rsp_valid = (r_state == c_dp_rsp);
    assign ks_rsp_valid = (r_state == c_ks_rsp);
    assign dp_rsp_data  = dp_rsp_valid ? r_res : '0;
    assign ks_rsp_data  = ks_rsp_valid ? r_res[31:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_last_ks <= 1'b0;
            r_beat    <= '0;
            r_src     <= '0;
            r_res     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (dp_req_ready) begin
                        r_src     <= dp_req_data;
                        r_res     <= '0;
                        r_beat    <= '0;
                        r_last_ks <= 1'b0;
                        r_state   <= c_dp_run;
                    end else if (ks_req_ready) begin
                        r_src     <= {96'b0, ks_req_data};
                        r_res     <= '0;
                        r_beat    <= '0;
                        r_last_ks <= 1'b1;
                        r_state   <= c_ks_run;
                    end
                end
                c_dp_run, c_ks_run: begin
                    // Result was cleared at grant, so OR-ing each beat's lanes is enough.
                    r_res <= r_res | w_lane_res;
                    if (w_last) begin
                        r_beat  <= '0;
                        r_state <= (r_state == c_dp_run) ? c_dp_rsp : c_ks_rsp;
                    end else begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
                c_dp_rsp: begin
                    if (dp_rsp_ready) begin
                        r_res   <= '0;
                        r_src   <= '0;
                        r_state <= c_idle;
                    end
                end
                c_ks_rsp: begin
                    if (ks_rsp_ready) begin
                        r_res   <= '0;
                        r_src   <= '0;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
